// File: rtl/cnn_frame_sequencer.sv
// Frame sequencer for a 32x32 CNN core: launches a frame, forwards pixels with one-cycle
// latency, then waits (bounded) for the core result and holds it until consumed.
`timescale 1ns/1ps
module cnn_frame_sequencer #(
    parameter int NUM_PIXELS     = 1024,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               abort,
    input  logic               s_valid,
    input  logic [7:0]         s_data,
    output logic               s_ready,
    output logic               cnn_start,
    output logic               cnn_pixel_valid,
    output logic [7:0]         cnn_pixel,
    input  logic               cnn_result_valid,
    input  logic signed [47:0] cnn_result,
    output logic               res_valid,
    input  logic               res_ready,
    output logic signed [47:0] res_data,
    output logic [7:0]         res_frame_id,
    output logic               busy,
    output logic               timeout_err
);
    localparam int PW = $clog2(NUM_PIXELS + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PW-1:0] LAST_PIX = PW'(NUM_PIXELS - 1);
    localparam logic [TW-1:0] LAST_TMO = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, START, STREAM, WAIT_RES} state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      pix_cnt_q, pix_cnt_d;
    logic [TW-1:0]      tmo_cnt_q, tmo_cnt_d;
    logic [7:0]         frame_cnt_q, frame_cnt_d;
    logic               cnn_start_q, cnn_start_d;
    logic               cnn_pixel_valid_q, cnn_pixel_valid_d;
    logic [7:0]         cnn_pixel_q, cnn_pixel_d;
    logic               res_valid_q, res_valid_d;
    logic signed [47:0] res_data_q, res_data_d;
    logic [7:0]         res_frame_id_q, res_frame_id_d;
    logic               timeout_err_q, timeout_err_d;

    assign s_ready         = (state_q == STREAM);
    assign busy            = (state_q != IDLE);
    assign cnn_start       = cnn_start_q;
    assign cnn_pixel_valid = cnn_pixel_valid_q;
    assign cnn_pixel       = cnn_pixel_q;
    assign res_valid       = res_valid_q;
    assign res_data        = res_data_q;
    assign res_frame_id    = res_frame_id_q;
    assign timeout_err     = timeout_err_q;

    always_comb begin
        state_d           = state_q;
        pix_cnt_d         = pix_cnt_q;
        tmo_cnt_d         = tmo_cnt_q;
        frame_cnt_d       = frame_cnt_q;
        cnn_start_d       = 1'b0;
        cnn_pixel_valid_d = 1'b0;
        cnn_pixel_d       = cnn_pixel_q;
        res_valid_d       = res_valid_q;
        res_data_d        = res_data_q;
        res_frame_id_d    = res_frame_id_q;
        timeout_err_d     = timeout_err_q;

        if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end

        // Abort wins over everything but leaves the held result and frame numbering alone.
        if (abort) begin
            state_d   = IDLE;
            pix_cnt_d = '0;
            tmo_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en && s_valid && !res_valid_q) begin
                        state_d     = START;
                        cnn_start_d = 1'b1;
                        pix_cnt_d   = '0;
                    end
                end
                START: begin
                    state_d = STREAM;
                end
                STREAM: begin
                    if (s_valid) begin
                        cnn_pixel_valid_d = 1'b1;
                        cnn_pixel_d       = s_data;
                        pix_cnt_d         = pix_cnt_q + PW'(1);
                        if (pix_cnt_q == LAST_PIX) begin
                            state_d   = WAIT_RES;
                            tmo_cnt_d = '0;
                        end
                    end
                end
                WAIT_RES: begin
                    // A result arriving on the timeout cycle is still captured.
                    if (cnn_result_valid) begin
                        res_valid_d    = 1'b1;
                        res_data_d     = cnn_result;
                        res_frame_id_d = frame_cnt_q;
                        frame_cnt_d    = frame_cnt_q + 8'd1;
                        state_d        = IDLE;
                    end else if (tmo_cnt_q == LAST_TMO) begin
                        timeout_err_d = 1'b1;
                        state_d       = IDLE;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + TW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q           <= IDLE;
            pix_cnt_q         <= '0;
            tmo_cnt_q         <= '0;
            frame_cnt_q       <= '0;
            cnn_start_q       <= 1'b0;
            cnn_pixel_valid_q <= 1'b0;
            cnn_pixel_q       <= '0;
            res_valid_q       <= 1'b0;
            res_data_q        <= '0;
            res_frame_id_q    <= '0;
            timeout_err_q     <= 1'b0;
        end else begin
            state_q           <= state_d;
            pix_cnt_q         <= pix_cnt_d;
            tmo_cnt_q         <= tmo_cnt_d;
            frame_cnt_q       <= frame_cnt_d;
            cnn_start_q       <= cnn_start_d;
            cnn_pixel_valid_q <= cnn_pixel_valid_d;
            cnn_pixel_q       <= cnn_pixel_d;
            res_valid_q       <= res_valid_d;
            res_data_q        <= res_data_d;
            res_frame_id_q    <= res_frame_id_d;
            timeout_err_q     <= timeout_err_d;
        end
    end
endmodule
